// File: rtl/wave_ram_port.sv
// wave_ram_port: 16-byte wave pattern RAM (FF30-FF3F) shared between the
// channel-3 playback fetch path and CPU reads/writes.
// While channel 3 plays, CPU accesses are steered to the byte channel 3 is
// addressing, and they are accepted only in a short window after each fetch
// (DMG behaviour).
// Build option: define WAVE_RAM_CGB_EN to remove the window restriction so
// that CPU accesses during playback always succeed (CGB behaviour).
module wave_ram_port #(
  parameter logic [15:0] BASE_ADDR     = 16'hFF30,
  parameter int          WINDOW_CYCLES = 2
) (
  input  logic        cery_2mhz,
  input  logic        apu_reset,
  input  logic [15:0] a,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_doe,
  input  logic        ch3_active,
  input  logic [3:0]  wave_a,
  input  logic        nib_sel,
  input  logic        fetch,
  output logic [3:0]  wave_play_d,
  output logic        wave_ram_rd
);

  // Pattern storage; deliberately has no reset so that contents survive apu_reset.
  logic [7:0] ram_q [16];

  logic [7:0] sample_buf_q, sample_buf_d;
  logic [7:0] cpu_dout_q,   cpu_dout_d;
  logic       cpu_doe_q,    cpu_doe_d;

  logic       hit;
  logic       fetch_go;
  logic [3:0] idx;
  logic       allowed;
  logic       wr_go;
  logic       rd_go;

  // CPU address decode; the window is aligned on a 16-byte boundary.
  assign hit = (a[15:4] == BASE_ADDR[15:4]);

  // A fetch has an effect only while channel 3 is playing.
  assign fetch_go = fetch & ch3_active;

  // During playback the CPU sees the byte channel 3 is addressing, not a[3:0].
  assign idx = ch3_active ? wave_a : a[3:0];

`ifdef WAVE_RAM_CGB_EN
  // CGB: CPU access is never blocked.
  assign allowed = 1'b1;
`else
  localparam logic [2:0] WIN_LOAD = 3'(WINDOW_CYCLES);

  logic [2:0] win_cnt_q, win_cnt_d;

  // Access window: reloads on each fetch, counts down to zero and is
  // cleared at once when playback stops.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (!ch3_active) begin
      win_cnt_d = 3'd0;
    end else if (fetch_go) begin
      win_cnt_d = WIN_LOAD;
    end else if (win_cnt_q != 3'd0) begin
      win_cnt_d = win_cnt_q - 3'd1;
    end
  end

  // Window counter register.
  always_ff @(posedge cery_2mhz) begin
    if (apu_reset) begin
      win_cnt_q <= 3'd0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  // DMG: during playback the CPU only gets through when a fetch is in
  // progress or the post-fetch window is still open.
  assign allowed = ~ch3_active | fetch_go | (win_cnt_q != 3'd0);
`endif

  // A write wins over a read in the same cycle; writes are dropped during reset.
  assign wr_go = cpu_wr & hit & allowed & ~apu_reset;
  assign rd_go = cpu_rd & hit & ~cpu_wr;

  // Next-state for the sample buffer and the CPU read port.
  always_comb begin
    sample_buf_d = sample_buf_q;
    if (fetch_go) begin
      // A write to the byte being fetched is passed straight through.
      sample_buf_d = wr_go ? cpu_din : ram_q[wave_a];
    end

    cpu_doe_d  = rd_go;
    cpu_dout_d = cpu_dout_q;
    if (rd_go) begin
      cpu_dout_d = allowed ? ram_q[idx] : 8'hFF;
    end
  end

  // RAM write port.
  always_ff @(posedge cery_2mhz) begin
    if (wr_go) begin
      ram_q[idx] <= cpu_din;
    end
  end

  // Sample buffer and CPU read response registers.
  always_ff @(posedge cery_2mhz) begin
    if (apu_reset) begin
      sample_buf_q <= 8'h00;
      cpu_dout_q   <= 8'hFF;
      cpu_doe_q    <= 1'b0;
    end else begin
      sample_buf_q <= sample_buf_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_doe_q    <= cpu_doe_d;
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign cpu_doe  = cpu_doe_q;

  // Playback nibble is silenced whenever channel 3 is off.
  assign wave_play_d = !ch3_active ? 4'h0 :
                       (nib_sel ? sample_buf_q[3:0] : sample_buf_q[7:4]);

  // RAM activity strobe used by channel 3 for its own clocking.
  assign wave_ram_rd = fetch | (cpu_rd & hit);

endmodule

// File: tb/tb_wave_ram_port.sv
// Testbench for wave_ram_port: directed scenarios followed by random
// stimulus, all checked against a cycle-level behavioural model.
module tb_wave_ram_port;

  localparam logic [15:0] BASE = 16'hFF30;
  localparam int          W    = 2;

  logic        clk = 1'b0;
  logic        apu_reset;
  logic [15:0] a;
  logic [7:0]  cpu_din;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_dout;
  logic        cpu_doe;
  logic        ch3_active;
  logic [3:0]  wave_a;
  logic        nib_sel;
  logic        fetch;
  logic [3:0]  wave_play_d;
  logic        wave_ram_rd;

  always #5 clk = ~clk;

  wave_ram_port #(.BASE_ADDR(BASE), .WINDOW_CYCLES(W)) dut (
    .cery_2mhz  (clk),
    .apu_reset  (apu_reset),
    .a          (a),
    .cpu_din    (cpu_din),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_dout   (cpu_dout),
    .cpu_doe    (cpu_doe),
    .ch3_active (ch3_active),
    .wave_a     (wave_a),
    .nib_sel    (nib_sel),
    .fetch      (fetch),
    .wave_play_d(wave_play_d),
    .wave_ram_rd(wave_ram_rd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
    end
  endtask

  // Reference model: RAM image, sample byte, read port, and the cycle of the
  // most recent fetch (the window is "at most W cycles since that fetch").
  logic [7:0] m_ram [16];
  logic [7:0] m_buf;
  logic [7:0] m_dout;
  logic       m_doe;
  int         cyc = 0;
  int         lf_cyc = 0;
  bit         lf_valid = 0;

  function automatic bit m_hit();
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 16);
  endfunction

  function automatic bit m_allowed();
    if (!ch3_active) return 1'b1;
`ifdef WAVE_RAM_CGB_EN
    return 1'b1;
`else
    return fetch || (lf_valid && (cyc - lf_cyc) <= W);
`endif
  endfunction

  function automatic logic [3:0] m_play();
    if (!ch3_active) return 4'h0;
    return nib_sel ? 4'(m_buf % 16) : 4'(m_buf / 16);
  endfunction

  task automatic model_step();
    bit ok, hit, wr, rd;
    int idx;
    if (apu_reset) begin
      m_buf    = 8'h00;
      m_dout   = 8'hFF;
      m_doe    = 1'b0;
      lf_valid = 0;
    end else begin
      ok  = m_allowed();
      hit = m_hit();
      idx = ch3_active ? int'(wave_a) : (int'(a) - int'(BASE)) & 15;
      wr  = cpu_wr && hit && ok;
      rd  = cpu_rd && hit && !cpu_wr;
      if (ch3_active && fetch) begin
        m_buf    = wr ? cpu_din : m_ram[wave_a];
        lf_cyc   = cyc;
        lf_valid = 1;
      end
      m_doe = rd;
      if (rd) m_dout = ok ? m_ram[idx] : 8'hFF;
      if (wr) m_ram[idx] = cpu_din;
      if (!ch3_active) lf_valid = 0;
    end
    cyc++;
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge.
  task automatic tick();
    @(negedge clk);
    check("play", 32'(wave_play_d), 32'(m_play()));
    check("ram_rd", 32'(wave_ram_rd), 32'(fetch || (cpu_rd && m_hit())));
    check("dout", 32'(cpu_dout), 32'(m_dout));
    check("doe", 32'(cpu_doe), 32'(m_doe));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    apu_reset = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    fetch     = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    a = addr; cpu_din = data; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr);
    a = addr; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  initial begin
    apu_reset = 1'b1; a = 16'h0000; cpu_din = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
    ch3_active = 1'b0; wave_a = 4'h0; nib_sel = 1'b0; fetch = 1'b0;
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_buf = 8'h00; m_dout = 8'hFF; m_doe = 1'b0;

    @(posedge clk);
    model_step();
    #1;
    check("rst_dout", 32'(cpu_dout), 32'hFF);
    check("rst_doe", 32'(cpu_doe), 32'h0);
    check("rst_play", 32'(wave_play_d), 32'h0);
    idle();

    // Known pattern: ram[i] = 0x20 + i
    for (int i = 0; i < 16; i++) cpu_write(BASE + 16'(i), 8'(8'h20 + i));
    tick();

    // Plain write then read with playback stopped
    cpu_write(16'hFF33, 8'hA5);
    cpu_read(16'hFF33);
    check("tp1_dout", 32'(cpu_dout), 32'hA5);
    check("tp1_doe", 32'(cpu_doe), 32'h1);
    tick();
    check("tp1_doe_drop", 32'(cpu_doe), 32'h0);

    // Fetch into the sample buffer, then both nibbles
    cpu_write(16'hFF35, 8'h3C);
    ch3_active = 1'b1; wave_a = 4'd5; fetch = 1'b1;
    tick();
    fetch = 1'b0; nib_sel = 1'b0; #1;
    check("tp2_hi", 32'(wave_play_d), 32'h3);
    nib_sel = 1'b1; #1;
    check("tp2_lo", 32'(wave_play_d), 32'hC);

    // Read inside and outside the post-fetch window
    wave_a = 4'd2; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    cpu_read(16'hFF3F);
    check("tp3_in", 32'(cpu_dout), 32'h22);
    tick();
    tick();
    cpu_read(16'hFF3F);
`ifdef WAVE_RAM_CGB_EN
    check("tp3_out", 32'(cpu_dout), 32'h22);
`else
    check("tp3_out", 32'(cpu_dout), 32'hFF);
`endif
    check("tp3_doe", 32'(cpu_doe), 32'h1);

    // Write outside the window (ram[9]), then inside it (ram[2])
    wave_a = 4'd9;
    cpu_write(16'hFF30, 8'h77);
    wave_a = 4'd2; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    cpu_write(16'hFF3A, 8'h77);
    ch3_active = 1'b0;
    tick();
    cpu_read(16'hFF39);
`ifdef WAVE_RAM_CGB_EN
    check("tp4_blocked", 32'(cpu_dout), 32'h77);
`else
    check("tp4_blocked", 32'(cpu_dout), 32'h29);
`endif
    cpu_read(16'hFF32);
    check("tp4_inside", 32'(cpu_dout), 32'h77);

    // Fetch and write to the same byte in one cycle
    ch3_active = 1'b1; wave_a = 4'd7; fetch = 1'b1;
    a = 16'hFF30; cpu_din = 8'h12; cpu_wr = 1'b1;
    tick();
    idle(); nib_sel = 1'b0; #1;
    check("tp5_play", 32'(wave_play_d), 32'h1);
    ch3_active = 1'b0;
    cpu_read(16'hFF37);
    check("tp5_ram", 32'(cpu_dout), 32'h12);

    // Reset during playback with a write in the window
    ch3_active = 1'b1; wave_a = 4'd3; fetch = 1'b1;
    tick();
    fetch = 1'b0; apu_reset = 1'b1; a = 16'hFF33; cpu_din = 8'hEE; cpu_wr = 1'b1;
    tick();
    idle();
    check("tp6_play", 32'(wave_play_d), 32'h0);
    check("tp6_dout", 32'(cpu_dout), 32'hFF);
    ch3_active = 1'b0;
    cpu_read(16'hFF33);
    check("tp6_ram", 32'(cpu_dout), 32'hA5);

    // Random traffic
    ch3_active = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      apu_reset = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) ch3_active = ~ch3_active;
      a       = ($urandom_range(3) != 0) ? BASE + 16'($urandom_range(15)) : 16'($urandom);
      cpu_din = 8'($urandom);
      cpu_rd  = ($urandom_range(3) == 0);
      cpu_wr  = ($urandom_range(3) == 0);
      fetch   = ($urandom_range(3) == 0);
      wave_a  = 4'($urandom_range(15));
      nib_sel = 1'($urandom_range(1));
      tick();
    end

    // Final readback of the whole RAM
    idle(); ch3_active = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      cpu_read(BASE + 16'(i));
      check("final_ram", 32'(cpu_dout), 32'(m_ram[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
